dual_cycle_sequencer: RTL and testbench
=======================================

Name: dual_cycle_sequencer

Overview:
- Cycle sequencer for the dual-cycle RISC-V core.
- Owns the FSM that alternates the fetch-decode-execute cycle with the memory/write-back cycle.
- Stretches the memory/write-back cycle while data memory has not acknowledged, and latches halt.
- Gates the control unit's regWrite/memWrite/ld outputs into timed PC, register-file and memory strobes; drives the control unit's nop input.

Parameters:
- RET_CNT_W, 32, width of retired-instruction counter.
- MAX_WAIT, 15, maximum cycles the memory/write-back cycle may wait for mem_ack before a bus error (must be >= 1).
- WAIT_W, 4, width of wait counter; must hold MAX_WAIT.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- halt_i  input  1  halt decode from control unit (opCode 7'b1111111).
- reg_write_i  input  1  control-unit regWrite for current instruction.
- mem_write_i  input  1  control-unit memWrite.
- ld_i  input  1  control-unit ld (lw/lh).
- mem_ack  input  1  data memory completion; sampled only while mem_req=1.
- nop_o  output  1  forces control unit to emit all-zero controls.
- ir_en  output  1  latch fetched instruction/decode results (execute cycle).
- pc_en  output  1  PC register update strobe.
- reg_we  output  1  register-file write strobe.
- mem_req  output  1  data memory access request.
- mem_we  output  1  qualifies mem_req as a write.
- state_o  output  3  current FSM state encoding.
- halted  output  1  core stopped (sticky).
- bus_err  output  1  memory timeout occurred (sticky).
- retired  output  RET_CNT_W  count of completed instructions.
- cycle_cnt  output  32  see Optional Feature.

Behaviour:
- States and encodings: BOOT=0, EX=1, WB=2, MWAIT=3, HALT=4.
- Reset (async, rst_n=0): state=BOOT, latched controls=0, wait counter=0, retired=0, halted=0, bus_err=0. Outputs during reset: nop_o=1, all strobes 0.
- BOOT: nop_o=1, no strobes; always -> EX next cycle. Gives one quiet cycle after reset release.
- EX: nop_o=0, ir_en=1. Latch {reg_write_i, mem_write_i, ld_i} into l_rw/l_mw/l_ld at clock edge.
  - halt_i=1: -> HALT; latches cleared; no pc_en, no retire.
  - Otherwise -> WB.
- WB, non-memory instruction (l_mw=0 and l_ld=0): reg_we=l_rw, pc_en=1, retired+=1 at edge; -> EX. Exactly two cycles per instruction.
- WB, memory instruction: mem_req=1, mem_we=l_mw, wait counter cleared to 0.
  - mem_ack=1 same cycle: reg_we=l_rw&l_ld, pc_en=1, retire; -> EX.
  - mem_ack=0: -> MWAIT.
- MWAIT: mem_req and mem_we held constant. Wait counter increments each cycle without ack.
  - mem_ack=1: completes exactly as in WB, same cycle (reg_we/pc_en combinational on mem_ack); -> EX.
  - mem_ack=0 with counter==MAX_WAIT-1: -> HALT with bus_err=1; no reg_we, no pc_en, no retire.
  - mem_ack and timeout in the same cycle: ack wins.
- HALT: halted=1, nop_o=1, all strobes 0. Leaves only via reset; halt_i and mem_ack ignored.
- Output decode:
  - nop_o, ir_en, mem_req, mem_we, halted: decoded from registered state and latches only (no input paths).
  - reg_we, pc_en: depend combinationally on mem_ack in WB/MWAIT.
- retired wraps modulo 2^RET_CNT_W, no saturation.
- Reset asserted mid-MWAIT: mem_req drops immediately (async); the pending access is abandoned.
- mem_ack outside WB/MWAIT: ignored.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined: cycle_cnt is a 32-bit counter. Reset 0; increments every clock while state != HALT; frozen in HALT; wraps at 2^32.
- Undefined: no counter flops; cycle_cnt tied to 0.

Test Plan:
- Reset release, then three R-type instructions (reg_write_i=1, others 0): state 0->1->2->1->2... One pc_en and one reg_we per 2 cycles; retired=3 after 7 cycles.
- lw with mem_ack held low 2 cycles, high on the 3rd: mem_req high 3 cycles; reg_we and pc_en only in the ack cycle; retired +1.
- sb (mem_write_i=1), mem_ack=1 in WB: mem_req=mem_we=1 for one cycle; reg_we=0; instruction takes 2 cycles.
- Load with mem_ack stuck low, MAX_WAIT=15: after 15 wait cycles, state=4, bus_err=1, halted=1; retired unchanged; later mem_ack ignored.
- halt_i=1 in EX after 5 instructions: state=4, halted=1, retired=5, nop_o=1. With SEQ_PERF_CNT_EN, cycle_cnt frozen from that point.
- rst_n pulsed low mid-MWAIT: mem_req drops without a clock edge; all counters 0; BOOT then EX after release.

Source files
------------

// File: rtl/dual_cycle_sequencer_if.sv
// Data-memory handshake between the cycle sequencer and data memory.
//   mem_req : access request, held for the whole memory/write-back cycle
//   mem_we  : qualifies mem_req as a write
//   mem_ack : memory completion, only meaningful while mem_req=1
// Modports: master = sequencer side, slave = memory side.
interface dual_cycle_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (output mem_req, output mem_we, input mem_ack);
    modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/dual_cycle_sequencer.sv
// Cycle sequencer for the dual-cycle RISC-V core. Alternates the fetch-decode-execute
// cycle (EX) with the memory/write-back cycle (WB), stretches WB while data memory has
// not acknowledged (MWAIT), and parks in HALT on a halt decode or a memory timeout.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   halt_i                 halt decode from the control unit
//   reg_write_i/mem_write_i/ld_i  control-unit outputs, latched in EX
//   mem_bus (master)       mem_req / mem_we / mem_ack handshake
//   nop_o                  forces all-zero controls (BOOT/HALT)
//   ir_en, pc_en, reg_we   instruction latch, PC update and register write strobes
//   state_o                BOOT=0 EX=1 WB=2 MWAIT=3 HALT=4
//   halted, bus_err        sticky stop / memory-timeout flags
//   retired                completed-instruction count (wraps)
//   cycle_cnt              free-running cycle count, only with SEQ_PERF_CNT_EN defined
//
// Optional feature macro: SEQ_PERF_CNT_EN (undefined: cycle_cnt tied to 0, no flops).
module dual_cycle_sequencer #(
    parameter int unsigned RET_CNT_W = 32,
    parameter int unsigned MAX_WAIT  = 15,
    parameter int unsigned WAIT_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    halt_i,
    input  logic                    reg_write_i,
    input  logic                    mem_write_i,
    input  logic                    ld_i,
    dual_cycle_sequencer_if.master  mem_bus,
    output logic                    nop_o,
    output logic                    ir_en,
    output logic                    pc_en,
    output logic                    reg_we,
    output logic [2:0]              state_o,
    output logic                    halted,
    output logic                    bus_err,
    output logic [RET_CNT_W-1:0]    retired,
    output logic [31:0]             cycle_cnt
);

    typedef enum logic [2:0] {
        StBoot  = 3'd0,
        StEx    = 3'd1,
        StWb    = 3'd2,
        StMwait = 3'd3,
        StHalt  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic                 l_rw_q, l_rw_d;
    logic                 l_mw_q, l_mw_d;
    logic                 l_ld_q, l_ld_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [RET_CNT_W-1:0] retired_q, retired_d;
    logic                 bus_err_q, bus_err_d;
    logic                 is_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StBoot;
            l_rw_q    <= 1'b0;
            l_mw_q    <= 1'b0;
            l_ld_q    <= 1'b0;
            wait_q    <= '0;
            retired_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            l_rw_q    <= l_rw_d;
            l_mw_q    <= l_mw_d;
            l_ld_q    <= l_ld_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign is_mem = l_mw_q | l_ld_q;

    always_comb begin
        state_d         = state_q;
        l_rw_d          = l_rw_q;
        l_mw_d          = l_mw_q;
        l_ld_d          = l_ld_q;
        wait_d          = wait_q;
        retired_d       = retired_q;
        bus_err_d       = bus_err_q;
        nop_o           = 1'b1;
        ir_en           = 1'b0;
        pc_en           = 1'b0;
        reg_we          = 1'b0;
        mem_bus.mem_req = 1'b0;
        mem_bus.mem_we  = 1'b0;

        unique case (state_q)
            StBoot: state_d = StEx;
            StEx: begin
                nop_o = 1'b0;
                ir_en = 1'b1;
                if (halt_i) begin
                    state_d = StHalt;
                    l_rw_d  = 1'b0;
                    l_mw_d  = 1'b0;
                    l_ld_d  = 1'b0;
                end else begin
                    state_d = StWb;
                    l_rw_d  = reg_write_i;
                    l_mw_d  = mem_write_i;
                    l_ld_d  = ld_i;
                end
            end
            StWb: begin
                nop_o = 1'b0;
                if (!is_mem) begin
                    reg_we    = l_rw_q;
                    pc_en     = 1'b1;
                    retired_d = retired_q + RET_CNT_W'(1);
                    state_d   = StEx;
                end else begin
                    mem_bus.mem_req = 1'b1;
                    mem_bus.mem_we  = l_mw_q;
                    wait_d          = '0;
                    if (mem_bus.mem_ack) begin
                        // Only loads write the register file on a memory instruction.
                        reg_we    = l_rw_q & l_ld_q;
                        pc_en     = 1'b1;
                        retired_d = retired_q + RET_CNT_W'(1);
                        state_d   = StEx;
                    end else begin
                        state_d = StMwait;
                    end
                end
            end
            StMwait: begin
                nop_o           = 1'b0;
                mem_bus.mem_req = 1'b1;
                mem_bus.mem_we  = l_mw_q;
                // Ack takes priority over the timeout in the same cycle.
                if (mem_bus.mem_ack) begin
                    reg_we    = l_rw_q & l_ld_q;
                    pc_en     = 1'b1;
                    retired_d = retired_q + RET_CNT_W'(1);
                    state_d   = StEx;
                end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                    bus_err_d = 1'b1;
                    state_d   = StHalt;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StHalt: ;
            default: state_d = StBoot;
        endcase
    end

    assign state_o = state_q;
    assign halted  = (state_q == StHalt);
    assign bus_err = bus_err_q;
    assign retired = retired_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
        end else if (state_q != StHalt) begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_dual_cycle_sequencer.sv
// Directed bench for dual_cycle_sequencer: R-type flow, load with wait states, store,
// memory timeout, halt, and asynchronous reset during a wait.
module tb_dual_cycle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt_i = 1'b0;
    logic        reg_write_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic        ld_i = 1'b0;
    logic        nop_o, ir_en, pc_en, reg_we, halted, bus_err;
    logic [2:0]  state_o;
    logic [31:0] retired;
    logic [31:0] cycle_cnt;

    int checks = 0;
    int errors = 0;

    dual_cycle_sequencer_if mem_if ();

    dual_cycle_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .halt_i      (halt_i),
        .reg_write_i (reg_write_i),
        .mem_write_i (mem_write_i),
        .ld_i        (ld_i),
        .mem_bus     (mem_if),
        .nop_o       (nop_o),
        .ir_en       (ir_en),
        .pc_en       (pc_en),
        .reg_we      (reg_we),
        .state_o     (state_o),
        .halted      (halted),
        .bus_err     (bus_err),
        .retired     (retired),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    // {state, nop, ir_en, pc_en, reg_we, mem_req, mem_we, halted, bus_err}
    logic [10:0] obs;
    assign obs = {state_o, nop_o, ir_en, pc_en, reg_we, mem_if.mem_req, mem_if.mem_we,
                  halted, bus_err};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        halt_i = 1'b0;
        reg_write_i = 1'b0;
        mem_write_i = 1'b0;
        ld_i = 1'b0;
        mem_if.mem_ack = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        rst_n = 1'b0;
        mem_if.mem_ack = 1'b0;
        cyc();
        e = {3'd0, 8'b1000_0000};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_out got %b exp %b", obs, e); end
        checks++;
        if (retired !== 32'd0 || cycle_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", retired, cycle_cnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL boot got %b exp %b", obs, e); end
        cyc();
        e = {3'd1, 8'b0100_0000};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL boot_to_ex got %b exp %b", obs, e); end
    endtask

    task automatic test_rtype();
        logic [10:0] e;
        apply_reset();
        cyc();
        reg_write_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            e = {3'd1, 8'b0100_0000};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rtype_ex%0d got %b exp %b", i, obs, e); end
            cyc();
            e = {3'd2, 8'b0011_0000};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rtype_wb%0d got %b exp %b", i, obs, e); end
            cyc();
        end
        reg_write_i = 1'b0;
        checks++;
        if (retired !== 32'd3 || state_o !== 3'd1) begin
            errors++; $display("FAIL rtype_retired got %0d st %0d exp 3 st 1", retired, state_o);
        end
    endtask

    task automatic test_load_wait();
        logic [10:0] e;
        apply_reset();
        cyc();
        ld_i = 1'b1;
        reg_write_i = 1'b1;
        cyc();
        ld_i = 1'b0;
        reg_write_i = 1'b0;
        #1;
        e = {3'd2, 8'b0000_1000};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL lw_wb got %b exp %b", obs, e); end
        cyc();
        e = {3'd3, 8'b0000_1000};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL lw_wait1 got %b exp %b", obs, e); end
        cyc();
        mem_if.mem_ack = 1'b1;
        #1;
        e = {3'd3, 8'b0011_1000};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL lw_ack got %b exp %b", obs, e); end
        cyc();
        mem_if.mem_ack = 1'b0;
        #1;
        e = {3'd1, 8'b0100_0000};
        checks++;
        if (obs !== e || retired !== 32'd1) begin
            errors++; $display("FAIL lw_done got %b ret %0d exp %b ret 1", obs, retired, e);
        end
    endtask

    task automatic test_store();
        logic [10:0] e;
        apply_reset();
        cyc();
        mem_write_i = 1'b1;
        reg_write_i = 1'b0;
        cyc();
        mem_write_i = 1'b0;
        mem_if.mem_ack = 1'b1;
        #1;
        e = {3'd2, 8'b0010_1100};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL sb_wb got %b exp %b", obs, e); end
        cyc();
        mem_if.mem_ack = 1'b0;
        #1;
        e = {3'd1, 8'b0100_0000};
        checks++;
        if (obs !== e || retired !== 32'd1) begin
            errors++; $display("FAIL sb_done got %b ret %0d exp %b ret 1", obs, retired, e);
        end
    endtask

    task automatic test_timeout();
        logic [10:0] e;
        apply_reset();
        cyc();
        ld_i = 1'b1;
        reg_write_i = 1'b1;
        cyc();
        ld_i = 1'b0;
        reg_write_i = 1'b0;
        for (int k = 0; k < 15; k++) begin
            cyc();
            e = {3'd3, 8'b0000_1000};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL to_wait%0d got %b exp %b", k, obs, e); end
        end
        cyc();
        e = {3'd4, 8'b1000_0011};
        checks++;
        if (obs !== e || retired !== 32'd0) begin
            errors++; $display("FAIL to_halt got %b ret %0d exp %b ret 0", obs, retired, e);
        end
        mem_if.mem_ack = 1'b1;
        #1;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL to_ack_ignored got %b exp %b", obs, e); end
        repeat (3) cyc();
        mem_if.mem_ack = 1'b0;
        checks++;
        if (obs !== e || retired !== 32'd0) begin
            errors++; $display("FAIL to_stuck got %b ret %0d exp %b ret 0", obs, retired, e);
        end
    endtask

    task automatic test_halt();
        logic [10:0] e;
        logic [31:0] cc_exp;
        apply_reset();
        cyc();
        reg_write_i = 1'b1;
        repeat (10) cyc();
        reg_write_i = 1'b0;
        halt_i = 1'b1;
        #1;
        e = {3'd1, 8'b0100_0000};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL halt_ex got %b exp %b", obs, e); end
        cyc();
        halt_i = 1'b0;
        e = {3'd4, 8'b1000_0010};
        checks++;
        if (obs !== e || retired !== 32'd5) begin
            errors++; $display("FAIL halt_state got %b ret %0d exp %b ret 5", obs, retired, e);
        end
`ifdef SEQ_PERF_CNT_EN
        cc_exp = 32'd12;
`else
        cc_exp = 32'd0;
`endif
        checks++;
        if (cycle_cnt !== cc_exp) begin
            errors++; $display("FAIL halt_cycles got %0d exp %0d", cycle_cnt, cc_exp);
        end
        repeat (3) cyc();
        checks++;
        if (obs !== e || cycle_cnt !== cc_exp) begin
            errors++; $display("FAIL halt_frozen got %b cc %0d exp %b cc %0d", obs, cycle_cnt, e,
                               cc_exp);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [10:0] e;
        apply_reset();
        cyc();
        reg_write_i = 1'b1;
        cyc();
        cyc();
        reg_write_i = 1'b0;
        ld_i = 1'b1;
        cyc();
        ld_i = 1'b0;
        cyc();
        e = {3'd3, 8'b0000_1000};
        checks++;
        if (obs !== e || retired !== 32'd1) begin
            errors++; $display("FAIL rmw_wait got %b ret %0d exp %b ret 1", obs, retired, e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        e = {3'd0, 8'b1000_0000};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL rmw_async got %b exp %b", obs, e); end
        checks++;
        if (retired !== 32'd0 || cycle_cnt !== 32'd0) begin
            errors++; $display("FAIL rmw_cnt got %0d/%0d exp 0/0", retired, cycle_cnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL rmw_boot got %b exp %b", obs, e); end
        cyc();
        e = {3'd1, 8'b0100_0000};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL rmw_ex got %b exp %b", obs, e); end
    endtask

    initial begin
        mem_if.mem_ack = 1'b0;
        test_reset();
        test_rtype();
        test_load_wait();
        test_store();
        test_timeout();
        test_halt();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
